// File: rtl/bist_response_analyzer.sv
// Read-side checker for the SRAM BIST: compares read words against expected data,
// counts miscompares, logs failing address/syndrome pairs and reports the verdict.
module bist_response_analyzer #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 4,
   parameter int LOG_DEPTH = 8,
   parameter int CNT_W     = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              CmpValid,
   input  logic [ADDR_W-1:0] CmpAddr,
   input  logic [DATA_W-1:0] CmpData,
   input  logic [DATA_W-1:0] CmpExp,
   input  logic              Done,
   output logic              TestDone,
   output logic              GoNoGo,
   output logic [CNT_W-1:0]  FailCount,
   output logic              Overflow,
   output logic              LogValid,
   output logic [ADDR_W-1:0] LogAddr,
   output logic [DATA_W-1:0] LogSyn,
   input  logic              LogReady
);

   localparam int PW = $clog2(LOG_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [PW:0]       wr_ptr, rd_ptr;
   logic [ADDR_W-1:0] mem_addr [LOG_DEPTH];
   logic [DATA_W-1:0] mem_syn  [LOG_DEPTH];
   logic [ADDR_W-1:0] held_addr;
   logic [DATA_W-1:0] held_syn;

   logic              empty, full, miss, pop, push, drop;
   logic [CNT_W-1:0]  cnt_next;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_syn;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

   // Start discards any compare or pop presented in the same cycle.
   assign miss = (state == S_RUN) && CmpValid && !Start && (CmpData != CmpExp);
   assign pop  = !empty && LogReady && !Start;
   assign push = miss && (!full || pop);
   assign drop = miss && full && !pop;

   always_comb begin
      cnt_next = FailCount;
      if (miss && (FailCount != {CNT_W{1'b1}}))
         cnt_next = FailCount + 1'b1;
   end

   assign head_addr = mem_addr[rd_ptr[PW-1:0]];
   assign head_syn  = mem_syn[rd_ptr[PW-1:0]];

   // When the log is empty the outputs keep showing the last head entry.
   assign LogValid = !empty;
   assign LogAddr  = empty ? held_addr : head_addr;
   assign LogSyn   = empty ? held_syn  : head_syn;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         TestDone  <= 1'b0;
         GoNoGo    <= 1'b0;
         FailCount <= '0;
         Overflow  <= 1'b0;
      end else if (Start) begin
         state     <= S_RUN;
         TestDone  <= 1'b0;
         GoNoGo    <= 1'b0;
         FailCount <= '0;
         Overflow  <= 1'b0;
      end else begin
         FailCount <= cnt_next;
         if (drop)
            Overflow <= 1'b1;
         if ((state == S_RUN) && Done) begin
            state    <= S_DONE;
            TestDone <= 1'b1;
            GoNoGo   <= (cnt_next == '0);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (Start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         held_addr <= '0;
         held_syn  <= '0;
      end else if (!empty) begin
         held_addr <= head_addr;
         held_syn  <= head_syn;
      end
   end

   always_ff @(posedge Clock) begin
      if (push) begin
         mem_addr[wr_ptr[PW-1:0]] <= CmpAddr;
         mem_syn[wr_ptr[PW-1:0]]  <= CmpData ^ CmpExp;
      end
   end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based
// model of the analyzer's session/verdict/fail-log behaviour.
module tb_bist_response_analyzer;

   logic       Clock = 1'b0;
   logic       Reset, Start, CmpValid, Done, LogReady;
   logic [7:0] CmpAddr;
   logic [3:0] CmpData, CmpExp;
   logic       TestDone, GoNoGo, Overflow, LogValid;
   logic [7:0] FailCount, LogAddr;
   logic [3:0] LogSyn;

   int checks = 0;
   int errors = 0;

   // reference model
   bit          m_run, m_td, m_go, m_ovf;
   int          m_cnt;
   logic [11:0] m_q[$];
   logic [11:0] m_last;

   bist_response_analyzer dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .CmpValid(CmpValid),
      .CmpAddr(CmpAddr), .CmpData(CmpData), .CmpExp(CmpExp), .Done(Done),
      .TestDone(TestDone), .GoNoGo(GoNoGo), .FailCount(FailCount),
      .Overflow(Overflow), .LogValid(LogValid), .LogAddr(LogAddr),
      .LogSyn(LogSyn), .LogReady(LogReady)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_td = 0; m_go = 0; m_ovf = 0; m_cnt = 0;
      m_q.delete(); m_last = '0;
   endtask

   task automatic check_all(input string tag);
      logic [11:0] head;
      head = (m_q.size() > 0) ? m_q[0] : m_last;
      chk({tag, ".TestDone"},  TestDone,  m_td);
      chk({tag, ".GoNoGo"},    GoNoGo,    m_go);
      chk({tag, ".FailCount"}, FailCount, m_cnt);
      chk({tag, ".Overflow"},  Overflow,  m_ovf);
      chk({tag, ".LogValid"},  LogValid,  m_q.size() > 0);
      chk({tag, ".LogAddr"},   LogAddr,   head[11:4]);
      chk({tag, ".LogSyn"},    LogSyn,    head[3:0]);
   endtask

   // One clock: drive at negedge, update model at the edge, check #1 later.
   task automatic cyc(input string tag, input bit st, input bit vld, input logic [7:0] a,
                      input logic [3:0] d, input logic [3:0] e, input bit dn, input bit rdy);
      bit pop, miss;
      int sz;
      @(negedge Clock);
      Start = st; CmpValid = vld; CmpAddr = a; CmpData = d; CmpExp = e;
      Done = dn; LogReady = rdy;
      @(posedge Clock);
      if (st) begin
         m_cnt = 0; m_ovf = 0; m_td = 0; m_go = 0; m_run = 1;
         if (m_q.size() > 0) m_last = m_q[0];
         m_q.delete();
      end else begin
         sz   = m_q.size();
         pop  = (sz > 0) && rdy;
         miss = m_run && vld && (d != e);
         if (pop) m_q.pop_front();
         if (miss) begin
            if (sz < 8 || pop) m_q.push_back({a, d ^ e});
            else m_ovf = 1;
            if (m_cnt < 255) m_cnt++;
         end
         if (m_run && dn) begin
            m_run = 0; m_td = 1; m_go = (m_cnt == 0);
         end
      end
      if (m_q.size() > 0) m_last = m_q[0];
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input bit rdy);
      cyc(tag, 0, 0, 8'h00, 4'h0, 4'h0, 0, rdy);
   endtask

   initial begin
      int n;
      logic [3:0] d, e;
      Reset = 1; Start = 0; CmpValid = 0; CmpAddr = 0; CmpData = 0; CmpExp = 0;
      Done = 0; LogReady = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge Clock); Reset = 0;

      // 1: clean pass over all 256 words
      cyc("t1.start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++) begin
         d = 4'($urandom);
         cyc("t1.cmp", 0, 1, 8'(i), d, d, i == 255, 0);
      end
      idle("t1.end", 0);
      chk("t1.go", GoNoGo, 1'b1);
      chk("t1.td", TestDone, 1'b1);

      // 2: single miscompare, then one pop
      cyc("t2.start", 1, 0, 0, 0, 0, 0, 0);
      cyc("t2.cmp", 0, 1, 8'h3C, 4'hA, 4'h5, 1, 0);
      chk("t2.cnt", FailCount, 8'd1);
      chk("t2.go", GoNoGo, 1'b0);
      chk("t2.addr", LogAddr, 8'h3C);
      chk("t2.syn", LogSyn, 4'hF);
      idle("t2.pop", 1);
      chk("t2.empty", LogValid, 1'b0);

      // 3: overflow with log blocked, then drain
      cyc("t3.start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         cyc("t3.cmp", 0, 1, 8'(i), 4'h1, 4'h0, 0, 0);
      chk("t3.cnt", FailCount, 8'd10);
      chk("t3.ovf", Overflow, 1'b1);
      n = 0;
      for (int i = 0; i < 20 && LogValid; i++) begin
         chk("t3.order", LogAddr, 8'(n));
         n++;
         idle("t3.drain", 1);
      end
      chk("t3.drained", n, 8);

      // 4: full log, simultaneous push and pop
      cyc("t4.start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         cyc("t4.fill", 0, 1, 8'(8'h40 + i), 4'h3, 4'h0, 0, 0);
      cyc("t4.pushpop", 0, 1, 8'h55, 4'h0, 4'h8, 0, 1);
      chk("t4.ovf", Overflow, 1'b0);
      chk("t4.head", LogAddr, 8'h41);

      // 5: counter saturation, then Start clears
      cyc("t5.start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         cyc("t5.cmp", 0, 1, 8'(i), 4'h2, 4'h4, 0, 1);
      chk("t5.sat", FailCount, 8'hFF);
      cyc("t5.restart", 1, 1, 0, 4'h1, 4'h0, 1, 1);
      chk("t5.clr", FailCount, 8'd0);

      // 6: reset mid-run with 3 entries logged
      for (int i = 0; i < 3; i++)
         cyc("t6.cmp", 0, 1, 8'(i), 4'h7, 4'h0, 0, 0);
      @(negedge Clock); Reset = 1; #1;
      model_reset();
      check_all("t6.async");
      @(negedge Clock); Reset = 0;
      cyc("t6.ign", 0, 1, 8'h10, 4'h1, 4'h0, 0, 1);
      cyc("t6.done", 0, 1, 8'h11, 4'h1, 4'h0, 1, 1);
      idle("t6.after", 0);
      chk("t6.td", TestDone, 1'b0);

      // random sessions
      cyc("rnd.start", 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         d = 4'($urandom);
         e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : d;
         cyc("rnd", $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
             8'($urandom), d, e, $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
